mem_port_arbiter: RTL

- Shares the core's single memory port between NUM_REQ requesters (index 0 = instruction fetch, 1 = data load/store).
- Round-robin grant on a valid/ready request channel; tracks outstanding transactions in a tag FIFO.
- Routes in-order memory responses back to the originating requester.
- Sits between the core's fetch/LSU units and the memory model instantiated under the simulation top.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_port_arbiter_fifo.sv | 64 ++++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  localparam int REQ_IFETCH  = 0;
  localparam int REQ_DATA    = 1;

  // Requester ids are sized for the largest supported requester count (4),
  // so one id type serves every legal NUM_REQ.
  localparam int MAX_NUM_REQ = 4;
  localparam int ID_W        = $clog2(MAX_NUM_REQ);

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;

  typedef logic [ID_W-1:0] req_id_t;

  // One request beat at the default widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]   addr;
    logic                    write;
    logic [DEF_DATA_W-1:0]   wdata;
    logic [DEF_DATA_W/8-1:0] wstrb;
  } mem_req_t;

  // Round-robin successor of a requester id, wrapping at num_req.
  function automatic req_id_t next_id(req_id_t id, int num_req);
    if (int'(id) >= num_req - 1) return '0;
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_fifo.sv
// Tag FIFO holding the requester id of every outstanding memory transaction.
module arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = slot_q[head_q];
  assign count    = count_q;

  // Pointer and occupancy next-state; pointers wrap naturally (depth is a power of two).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + 1'b1;
    if (do_pop)  head_d = head_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Id storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) slot_q[tail_q] <= push_data;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters,
// with in-order response routing through a tag FIFO.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_wstrb,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic                          mem_req_write,
  output logic [DATA_W-1:0]             mem_req_wdata,
  output logic [DATA_W/8-1:0]           mem_req_wstrb,
  input  logic                          mem_rsp_valid,
  output logic                          mem_rsp_ready,
  input  logic [DATA_W-1:0]             mem_rsp_rdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [$clog2(MAX_OUT):0]      outstanding,
  output logic                          proto_err
);

  localparam int SW = DATA_W / 8;

  req_id_t rr_ptr_q, rr_ptr_d;
  req_id_t locked_id_q, locked_id_d;
  logic    lock_q, lock_d;
  logic    proto_err_q, proto_err_d;

  req_id_t grant;
  req_id_t head_id;
  logic    found;
  int      idx;
  logic    fifo_full, fifo_empty;
  logic    req_hs, rsp_hs;
  logic    head_ready;

  // Grant: hold the locked id while a request waits, otherwise first valid from rr_ptr upward.
  always_comb begin
    grant = rr_ptr_q;
    found = 1'b0;
    idx   = 0;
    if (lock_q) begin
      grant = locked_id_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && (i == idx) && req_valid[i]) begin
            grant = req_id_t'(i);
            found = 1'b1;
          end
        end
      end
    end
  end

  // Request path: mux the granted requester onto the memory port; everything is held off in reset.
  always_comb begin
    mem_req_valid = reset & (|req_valid) & ~fifo_full;
    mem_req_addr  = '0;
    mem_req_write = 1'b0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    req_ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(grant) == i) begin
        mem_req_addr  = req_addr[i*ADDR_W +: ADDR_W];
        mem_req_write = req_write[i];
        mem_req_wdata = req_wdata[i*DATA_W +: DATA_W];
        mem_req_wstrb = req_wstrb[i*SW +: SW];
        req_ready[i]  = reset & mem_req_ready & ~fifo_full;
      end
    end
  end

  // Response path: steer the in-order response to the requester at the FIFO head.
  always_comb begin
    rsp_valid  = '0;
    head_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(head_id) == i) begin
        rsp_valid[i] = reset & mem_rsp_valid & ~fifo_empty;
        head_ready   = rsp_ready[i];
      end
    end
    mem_rsp_ready = reset & head_ready & ~fifo_empty;
    rsp_rdata     = reset ? mem_rsp_rdata : '0;
  end

  assign req_hs    = mem_req_valid & mem_req_ready;
  assign rsp_hs    = mem_rsp_valid & mem_rsp_ready;
  assign proto_err = proto_err_q;

  // Round-robin pointer, grant lock and protocol-error next-state.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    proto_err_d = proto_err_q | (mem_rsp_valid & fifo_empty);
    if (req_hs) rr_ptr_d = next_id(grant, NUM_REQ);
    if (mem_req_valid && !mem_req_ready) begin
      lock_d      = 1'b1;
      locked_id_d = grant;
    end else if (req_hs) begin
      lock_d      = 1'b0;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      locked_id_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      proto_err_q <= proto_err_d;
    end
  end

  arb_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (ID_W)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (req_hs),
    .push_data (grant),
    .pop       (rsp_hs),
    .pop_data  (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

endmodule
